// File: rtl/umul_pkg.sv
// ============================================================================
// Module   : umul_pkg
// Brief    : Shared state encoding and stream-length helper for the uMUL_bi
//            job sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package umul_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic int unsigned streamLen(input int unsigned bw);
      return 32'd1 << bw;
   endfunction

endpackage

`default_nettype wire

// File: rtl/umul_ones_acc.sv
// ============================================================================
// Module   : umul_ones_acc
// Brief    : Clearable, enabled counter of 1s seen on a unary product stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module umul_ones_acc #(
   parameter int WIDTH = 9
) (
   input  logic             iClk,
   input  logic             iRstN,
   input  logic             iClr,
   input  logic             iEn,
   input  logic             iBit,
   output logic [WIDTH-1:0] oCount
);

   logic [WIDTH-1:0] rCount;

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         rCount <= '0;
      end else if (iClr) begin
         rCount <= '0;
      end else if (iEn) begin
         rCount <= rCount + {{(WIDTH-1){1'b0}}, iBit};
      end
   end

   assign oCount = rCount;

endmodule

`default_nettype wire

// File: rtl/umul_bi_seq_ctrl.sv
// ============================================================================
// Module   : umul_bi_seq_ctrl
// Brief    : Job sequencer for one bipolar unary multiplier: load B, clear the
//            RNGs, stream A as a thermometer code, count product-stream 1s.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module umul_bi_seq_ctrl
   import umul_pkg::*;
#(
   parameter int BITWIDTH = 8
) (
   input  logic                iClk,
   input  logic                iRstN,
   input  logic                iValid,
   output logic                oReady,
   input  logic [BITWIDTH-1:0] iA,
   input  logic [BITWIDTH-1:0] iB,
   output logic                oValid,
   input  logic                iReady,
   output logic [BITWIDTH:0]   oResult,
   output logic                oMulA,
   output logic [BITWIDTH-1:0] oMulB,
   output logic                oMulLoadB,
   output logic                oMulClr,
   input  logic                iMulOut
);

   localparam int unsigned          STREAM_LEN = streamLen(BITWIDTH);
   localparam logic [BITWIDTH-1:0]  LAST_CNT   = BITWIDTH'(STREAM_LEN - 1);

   state_t              rState;
   state_t              wNextState;
   logic [BITWIDTH-1:0] rABuf;
   logic [BITWIDTH-1:0] rMulB;
   logic [BITWIDTH-1:0] rCnt;
   logic [BITWIDTH:0]   wAcc;
   logic                wAccept;
   logic                wAccClr;
   logic                wAccEn;

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         rState <= S_IDLE;
      end else begin
         rState <= wNextState;
      end
   end

   always_comb begin
      wNextState = rState;
      oReady     = 1'b0;
      oValid     = 1'b0;
      oMulLoadB  = 1'b0;
      oMulClr    = 1'b0;
      wAccClr    = 1'b0;
      wAccEn     = 1'b0;
      wAccept    = 1'b0;
      case (rState)
         S_IDLE: begin
            oReady  = 1'b1;
            wAccept = iValid;
            if (iValid) begin
               wNextState = S_LOAD;
            end
         end
         S_LOAD: begin
            oMulLoadB  = 1'b1;
            oMulClr    = 1'b1;
            wAccClr    = 1'b1;
            wNextState = S_RUN;
         end
         S_RUN: begin
            wAccEn = 1'b1;
            if (rCnt == LAST_CNT) begin
               wNextState = S_DONE;
            end
         end
         S_DONE: begin
            oValid = 1'b1;
            if (iReady) begin
               wNextState = S_IDLE;
            end
         end
         default: wNextState = S_IDLE;
      endcase
   end

   // Operands are captured only on an accepted handshake; cnt restarts in LOAD.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         rABuf <= '0;
         rMulB <= '0;
         rCnt  <= '0;
      end else begin
         if (wAccept) begin
            rABuf <= iA;
            rMulB <= iB;
         end
         if (rState == S_LOAD) begin
            rCnt <= '0;
         end else if (rState == S_RUN) begin
            rCnt <= rCnt + 1'b1;
         end
      end
   end

   umul_ones_acc #(
      .WIDTH (BITWIDTH + 1)
   ) uOnesAcc (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iClr   (wAccClr),
      .iEn    (wAccEn),
      .iBit   (iMulOut),
      .oCount (wAcc)
   );

   // Thermometer stream: A_buf ones followed by zeros, only while running.
   assign oMulA   = (rState == S_RUN) && (rABuf > rCnt);
   assign oMulB   = rMulB;
   assign oResult = oValid ? wAcc : '0;

endmodule

`default_nettype wire
